// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: FSM state encodings and recurrence-depth limits shared by the seq_gen files.
package seq_gen_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int K_MIN = 2;
    localparam int K_MAX = 8;
endpackage

// File: rtl/seq_gen_sum.sv
// seq_gen_sum: combinational K-input adder producing the next term and its overflow bit.
// SEQ_GEN_SAT_EN clamps an overflowing sum to all-ones instead of wrapping.
module seq_gen_sum #(
    parameter int W = 96,
    parameter int K = 2
) (
    input  logic [K-1:0][W-1:0] win,
    output logic [W-1:0]        sum,
    output logic                ovf
);
    localparam int SW = W + $clog2(K);
    logic [SW-1:0] acc;
    always_comb begin
        acc = '0;
        for (int i = 0; i < K; i++) acc = acc + SW'(win[i]);
    end
    assign ovf = |acc[SW-1:W];
`ifdef SEQ_GEN_SAT_EN
    assign sum = ovf ? '1 : acc[W-1:0];
`else
    assign sum = acc[W-1:0];
`endif
endmodule

// File: rtl/seq_gen.sv
// seq_gen: additive-recurrence sequence generator streaming K-term sums over valid/ready.
// Optional saturation via SEQ_GEN_SAT_EN (default build wraps mod 2^W).
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int W  = 96,
    parameter int K  = 2,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  seed0,
    input  logic [W-1:0]  seed1,
    input  logic [CW-1:0] n_terms,
    output logic [W-1:0]  y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [CW-1:0] idx,
    output logic          busy,
    output logic          done,
    output logic          ovf
);
    if (K < K_MIN || K > K_MAX) begin : g_bad_k
        $error("seq_gen: K out of range");
    end
    state_t state, nxt;
    // win[0] is the term after y; nxt_ovf is its overflow bit, folded into ovf when it is emitted
    logic [K-1:0][W-1:0] win, init;
    logic [CW-1:0] last;
    logic [W-1:0] sum;
    logic sum_ovf, nxt_ovf, go, hs;
    seq_gen_sum #(.W(W), .K(K)) u_sum (.win(win), .sum(sum), .ovf(sum_ovf));
    assign go = state == IDLE && start;
    assign hs = y_valid && y_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (go) nxt = n_terms == '0 ? DONE : RUN;
        else if (state == RUN && hs && idx == last) nxt = DONE;
        else if (state == DONE) nxt = IDLE;
    end
    always_comb begin
        y_valid = state == RUN;
        busy    = state == RUN;
        done    = state == DONE;
    end
    always_comb begin
        init    = '0;
        init[1] = seed0;
        init[0] = seed1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win     <= '0;
            y       <= '0;
            idx     <= '0;
            last    <= '0;
            ovf     <= 1'b0;
            nxt_ovf <= 1'b0;
        end else if (go) begin
            win     <= init;
            y       <= seed0;
            idx     <= '0;
            last    <= n_terms - 1'b1;
            ovf     <= 1'b0;
            nxt_ovf <= 1'b0;
        end else if (hs && idx != last) begin
            win     <= {win[K-2:0], sum};
            y       <= win[0];
            idx     <= idx + 1'b1;
            ovf     <= ovf | nxt_ovf;
            nxt_ovf <= sum_ovf;
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: scoreboard bench for seq_gen (W=96/K=2, W=64/K=2, W=32/K=3 instances).
module tb_seq_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, start, y_ready;
    logic [127:0] seed0, seed1;
    logic [15:0] n_terms;
    int sel;
    logic [95:0] ya;
    logic [63:0] yb;
    logic [31:0] yc;
    logic [15:0] ia, ib, ic;
    logic va, vb, vc, ba, bb, bc, da, db, dc, oa, ob, oc;
    seq_gen #(.W(96), .K(2), .CW(16)) u_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .seed0(seed0[95:0]), .seed1(seed1[95:0]),
        .n_terms(n_terms), .y(ya), .y_valid(va), .y_ready(y_ready), .idx(ia), .busy(ba), .done(da), .ovf(oa));
    seq_gen #(.W(64), .K(2), .CW(16)) u_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .seed0(seed0[63:0]), .seed1(seed1[63:0]),
        .n_terms(n_terms), .y(yb), .y_valid(vb), .y_ready(y_ready), .idx(ib), .busy(bb), .done(db), .ovf(ob));
    seq_gen #(.W(32), .K(3), .CW(16)) u_c (
        .clk(clk), .rst(rst), .start(start && sel == 2), .seed0(seed0[31:0]), .seed1(seed1[31:0]),
        .n_terms(n_terms), .y(yc), .y_valid(vc), .y_ready(y_ready), .idx(ic), .busy(bc), .done(dc), .ovf(oc));
    logic [127:0] oy;
    logic [15:0] oi;
    logic ovv, od, oo;
    always_comb begin
        oy  = sel == 0 ? {32'b0, ya} : sel == 1 ? {64'b0, yb} : {96'b0, yc};
        oi  = sel == 0 ? ia : sel == 1 ? ib : ic;
        ovv = sel == 0 ? va : sel == 1 ? vb : vc;
        od  = sel == 0 ? da : sel == 1 ? db : dc;
        oo  = sel == 0 ? oa : sel == 1 ? ob : oc;
    end
    typedef struct {logic [127:0] t; logic o; int i;} exp_t;
    exp_t q[$];
    int total, bad;
    logic [127:0] cap93, cap94;
    logic cov93, cov94;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference: full term history, t(i) = sum of the K previous terms, negatives taken as 0
    task automatic build(input int w, input int k, input logic [127:0] a, input logic [127:0] b, input int n);
        logic [127:0] h[$];
        logic [131:0] s;
        logic [127:0] m, v;
        logic so, ov;
        m = (128'b1 << w) - 1;
        so = 1'b0;
        q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 0) s = {4'b0, a};
            else if (i == 1) s = {4'b0, b};
            else begin
                s = '0;
                for (int j = 1; j <= k; j++) if (i - j >= 0) s = s + {4'b0, h[i-j]};
            end
            ov = s > {4'b0, m};
`ifdef SEQ_GEN_SAT_EN
            v = ov ? m : s[127:0] & m;
`else
            v = s[127:0] & m;
`endif
            so = so | ov;
            h.push_back(v);
            q.push_back('{v, so, i});
        end
    endtask

    task automatic run(input int s, input int w, input int k, input logic [127:0] a, input logic [127:0] b,
                       input int n, input bit rnd, input bit mid);
        exp_t e;
        int cyc, dn;
        bit held, fin;
        logic [127:0] py;
        logic [15:0] pi;
        build(w, k, a, b, n);
        @(negedge clk);
        sel = s; seed0 = a; seed1 = b; n_terms = 16'(n); start = 1'b1; y_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 0; dn = 0; held = 0; fin = 0; py = '0; pi = '0;
        while (!fin && cyc < 2000) begin
            if (od) begin dn++; fin = 1; end
            if (ovv) begin
                if (held) begin
                    chk("hold_y", oy, py);
                    chk("hold_idx", 128'(oi), 128'(pi));
                end
                y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                held = !y_ready; py = oy; pi = oi;
                if (y_ready) begin
                    e = q.size() != 0 ? q.pop_front() : '{'x, 1'bx, -1};
                    chk("term", oy, e.t);
                    chk("idx", 128'(oi), 128'(e.i[15:0]));
                    chk("ovf", 128'(oo), 128'(e.o));
                    if (s == 1 && oi == 16'd93) begin cap93 = oy; cov93 = oo; end
                    if (s == 1 && oi == 16'd94) begin cap94 = oy; cov94 = oo; end
                end
            end else y_ready = 1'b0;
            if (mid) begin
                start = cyc == 3;
                seed0 = cyc == 3 ? 128'd77 : a;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; y_ready = 1'b0;
        chk("finished", 128'(fin), 128'(1));
        chk("left", 128'(q.size()), 128'(0));
        chk("done_once", 128'(od), 128'(0));
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; start = 1'b0; y_ready = 1'b0; sel = 0;
        seed0 = '0; seed1 = '0; n_terms = '0;
        cap93 = '0; cap94 = '0; cov93 = 1'bx; cov94 = 1'bx;
        #12;
        chk("rst_y", {32'b0, ya}, 128'd0);
        chk("rst_idx", 128'(ia), 128'd0);
        chk("rst_valid", 128'(va), 128'd0);
        chk("rst_busy", 128'(ba), 128'd0);
        chk("rst_done", 128'(da), 128'd0);
        chk("rst_ovf", 128'(oa), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        run(0, 96, 2, 128'd0, 128'd1, 100, 0, 0);
        chk("t99", {32'b0, ya}, 128'd218922995834555169026);
        chk("idx_hold", 128'(ia), 128'd99);
        chk("ovf96", 128'(oa), 128'd0);
        run(0, 96, 2, 128'd2, 128'd1, 7, 0, 1);
        chk("lucas_last", {32'b0, ya}, 128'd18);
        run(2, 32, 3, 128'd0, 128'd1, 7, 0, 0);
        chk("trib_last", {96'b0, yc}, 128'd13);
        run(1, 64, 2, 128'd0, 128'd1, 100, 0, 0);
        chk("t93_64", cap93, 128'd12200160415121876738);
        chk("ovf93_64", 128'(cov93), 128'd0);
`ifdef SEQ_GEN_SAT_EN
        chk("t94_64", cap94, 128'd18446744073709551615);
`else
        chk("t94_64", cap94, 128'd1293530146158671551);
`endif
        chk("ovf94_64", 128'(cov94), 128'd1);
        run(0, 96, 2, 128'd5, 128'd3, 60, 1, 0);
        @(negedge clk);
        sel = 0; n_terms = '0; seed0 = 128'd9; seed1 = 128'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("n0_done", 128'(da), 128'd1);
        chk("n0_valid", 128'(va), 128'd0);
        chk("n0_busy", 128'(ba), 128'd0);
        @(negedge clk);
        chk("n0_done_end", 128'(da), 128'd0);
        chk("n0_valid_end", 128'(va), 128'd0);
        seed0 = '0; seed1 = 128'd1; n_terms = 16'd20; start = 1'b1; y_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && ia != 16'd5; c++) @(negedge clk);
        chk("reach5", 128'(ia), 128'd5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_y", {32'b0, ya}, 128'd0);
        chk("mid_rst_idx", 128'(ia), 128'd0);
        chk("mid_rst_valid", 128'(va), 128'd0);
        chk("mid_rst_busy", 128'(ba), 128'd0);
        chk("mid_rst_done", 128'(da), 128'd0);
        chk("mid_rst_ovf", 128'(oa), 128'd0);
        y_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run(0, 96, 2, 128'd0, 128'd1, 10, 0, 0);
        chk("restart_last", {32'b0, ya}, 128'd34);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
